// File: rtl/arb_requester.sv
// arb_requester
// Client-side companion of the four-channel request/grant arbiter. Every channel
// counts incoming job pulses. While work is pending, the channel raises its
// request. Once granted, it holds the request for a fixed burst and then drops it
// for exactly one cycle. The block also watches the grant bus for illegal
// behaviour and records each kind of violation in a sticky flag.
//
// Ports
//   clock         rising-edge clock for all logic
//   reset_n       synchronous active-low reset
//   job_in[NCH]   one-cycle pulse per bit, adds one pending job to that channel
//   grant[NCH]    grant from the arbiter, indexed like req
//   clr_err       one-cycle pulse, clears every sticky error flag
//   req[NCH]      registered request to the arbiter
//   xfer[NCH]     high during the channel's data phase
//   done[NCH]     one-cycle pulse after a burst completes cleanly
//   err_timeout   sticky, per channel: request waited TIMEOUT cycles without a grant
//   err_drop      sticky, per channel: grant vanished during the data phase
//   err_spurious  sticky: grant seen on a channel that was not requesting
//   err_multi     sticky: more than one grant bit high in the same cycle
//   err_ovf       sticky: job pulse arrived while the channel counter was at QMAX
module arb_requester #(
  parameter int NCH     = 4,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 15,
  parameter int QMAX    = 7
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [NCH-1:0] job_in,
  input  logic [NCH-1:0] grant,
  input  logic           clr_err,
  output logic [NCH-1:0] req,
  output logic [NCH-1:0] xfer,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] err_timeout,
  output logic [NCH-1:0] err_drop,
  output logic           err_spurious,
  output logic           err_multi,
  output logic           err_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  localparam logic [2:0] QMAX_C    = 3'(QMAX);
  localparam logic [3:0] BURST_C   = 4'(BURST);
  // The wait counter starts at zero on REQ entry, so the TIMEOUT-th request
  // cycle is the one that sees TIMEOUT-1.
  localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 1);

  // True when two or more bits are set. Clearing the lowest set bit still leaves
  // something behind in that case.
  function automatic logic multi_hot(input logic [NCH-1:0] v);
    logic [NCH-1:0] one;
    one = {{(NCH-1){1'b0}}, 1'b1};
    return (v & (v - one)) != {NCH{1'b0}};
  endfunction

  logic [NCH-1:0] req_s, xfer_s, done_s, to_s, drop_s, ovf_s, spur_s;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t     state_r, state_s;
    logic [2:0] pend_r, pend_s;
    logic [7:0] wait_r, wait_s;
    logic [3:0] burst_r, burst_s;
    logic       accept_s, done_ev_s, to_ev_s, drop_ev_s, ovf_ev_s;

    // Channel state register and its pending/wait/burst counters
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        state_r <= ST_IDLE;
        pend_r  <= 3'd0;
        wait_r  <= 8'd0;
        burst_r <= 4'd0;
      end else begin
        state_r <= state_s;
        pend_r  <= pend_s;
        wait_r  <= wait_s;
        burst_r <= burst_s;
      end
    end

    // Channel next-state, counter updates and per-cycle event detection
    always_comb begin
      state_s   = state_r;
      pend_s    = pend_r;
      wait_s    = 8'd0;
      burst_s   = burst_r;
      accept_s  = 1'b0;
      done_ev_s = 1'b0;
      to_ev_s   = 1'b0;
      drop_ev_s = 1'b0;
      ovf_ev_s  = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pend_r != 3'd0) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          // A grant on the last allowed wait cycle is still accepted.
          if (grant[i]) begin
            accept_s = 1'b1;
            state_s  = ST_XFER;
            burst_s  = BURST_C;
          end else if (wait_r == TO_LAST_C) begin
            to_ev_s = 1'b1;
            state_s = ST_REL;
          end else begin
            wait_s = wait_r + 8'd1;
          end
        end
        ST_XFER: begin
          // A dropped grant wins, even on the final beat. The burst then
          // ends without a done pulse.
          if (!grant[i]) begin
            drop_ev_s = 1'b1;
            state_s   = ST_REL;
          end else if (burst_r == 4'd1) begin
            done_ev_s = 1'b1;
            state_s   = ST_REL;
          end else begin
            burst_s = burst_r - 4'd1;
          end
        end
        ST_REL: begin
          if (pend_r != 3'd0) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase

      // A new job and an accepted grant in the same cycle cancel each other.
      if (job_in[i] && !accept_s) begin
        if (pend_r == QMAX_C) begin
          ovf_ev_s = 1'b1;
        end else begin
          pend_s = pend_r + 3'd1;
        end
      end else if (accept_s && !job_in[i]) begin
        pend_s = pend_r - 3'd1;
      end else begin
        pend_s = pend_r;
      end
    end

    assign req_s[i]  = (state_s == ST_REQ) || (state_s == ST_XFER);
    assign xfer_s[i] = (state_s == ST_XFER);
    assign done_s[i] = done_ev_s;
    assign to_s[i]   = to_ev_s;
    assign drop_s[i] = drop_ev_s;
    assign ovf_s[i]  = ovf_ev_s;
    assign spur_s[i] = grant[i] && ((state_r == ST_IDLE) || (state_r == ST_REL));
  end

  logic [NCH-1:0] req_r, xfer_r, done_r, to_err_r, drop_err_r;
  logic           spur_err_r, multi_err_r, ovf_err_r;
  logic [NCH-1:0] clr_mask_s;

  assign clr_mask_s = {NCH{clr_err}};

  // Output registers. In the sticky flags a new error overrides a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_r       <= {NCH{1'b0}};
      xfer_r      <= {NCH{1'b0}};
      done_r      <= {NCH{1'b0}};
      to_err_r    <= {NCH{1'b0}};
      drop_err_r  <= {NCH{1'b0}};
      spur_err_r  <= 1'b0;
      multi_err_r <= 1'b0;
      ovf_err_r   <= 1'b0;
    end else begin
      req_r       <= req_s;
      xfer_r      <= xfer_s;
      done_r      <= done_s;
      to_err_r    <= (to_err_r & ~clr_mask_s) | to_s;
      drop_err_r  <= (drop_err_r & ~clr_mask_s) | drop_s;
      spur_err_r  <= (spur_err_r & ~clr_err) | (|spur_s);
      multi_err_r <= (multi_err_r & ~clr_err) | multi_hot(grant);
      ovf_err_r   <= (ovf_err_r & ~clr_err) | (|ovf_s);
    end
  end

  assign req          = req_r;
  assign xfer         = xfer_r;
  assign done         = done_r;
  assign err_timeout  = to_err_r;
  assign err_drop     = drop_err_r;
  assign err_spurious = spur_err_r;
  assign err_multi    = multi_err_r;
  assign err_ovf      = ovf_err_r;

endmodule

// File: tb/tb_arb_requester.sv
`timescale 1ns/1ps
module tb_arb_requester;
  localparam int NCH = 4, BURST = 4, TIMEOUT = 15, QMAX = 7;
  localparam int M_IDLE = 0, M_REQ = 1, M_XFER = 2, M_REL = 3;

  logic clock = 1'b0, reset_n = 1'b0, clr_err = 1'b0;
  logic [NCH-1:0] job_in = '0, grant = '0;
  logic [NCH-1:0] req, xfer, done, err_timeout, err_drop;
  logic err_spurious, err_multi, err_ovf;

  arb_requester #(.NCH(NCH), .BURST(BURST), .TIMEOUT(TIMEOUT), .QMAX(QMAX)) dut (
    .clock(clock), .reset_n(reset_n), .job_in(job_in), .grant(grant), .clr_err(clr_err),
    .req(req), .xfer(xfer), .done(done), .err_timeout(err_timeout), .err_drop(err_drop),
    .err_spurious(err_spurious), .err_multi(err_multi), .err_ovf(err_ovf));

  always #5 clock = ~clock;

  int n_checks = 0, n_errors = 0;
  logic chk_en = 1'b0;
  logic [NCH-1:0] manual_g = '0, auto_en = '0;

  // Model of the client: job queue depth, channel phase, and cycles spent in that phase
  int m_mode [NCH];
  int m_pend [NCH];
  int m_wait [NCH];
  int m_left [NCH];
  logic [NCH-1:0] e_req = '0, e_xfer = '0, e_done = '0, e_to = '0, e_drop = '0;
  logic e_spur = 1'b0, e_multi = 1'b0, e_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit took;
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = M_IDLE; m_pend[c] = 0; m_wait[c] = 0; m_left[c] = 0;
      end
      e_req = '0; e_xfer = '0; e_done = '0; e_to = '0; e_drop = '0;
      e_spur = 1'b0; e_multi = 1'b0; e_ovf = 1'b0;
    end else begin
      if (clr_err) begin
        e_to = '0; e_drop = '0; e_spur = 1'b0; e_multi = 1'b0; e_ovf = 1'b0;
      end
      if ($countones(grant) > 1) e_multi = 1'b1;
      e_done = '0;
      for (int c = 0; c < NCH; c++) begin
        took = 1'b0;
        if (grant[c] && (m_mode[c] == M_IDLE || m_mode[c] == M_REL)) e_spur = 1'b1;
        case (m_mode[c])
          M_IDLE: if (m_pend[c] > 0) begin m_mode[c] = M_REQ; m_wait[c] = 0; end
          M_REQ: begin
            if (grant[c]) begin
              took = 1'b1; m_mode[c] = M_XFER; m_left[c] = BURST;
            end else begin
              m_wait[c]++;
              if (m_wait[c] >= TIMEOUT) begin e_to[c] = 1'b1; m_mode[c] = M_REL; end
            end
          end
          M_XFER: begin
            m_left[c]--;
            if (!grant[c]) begin
              e_drop[c] = 1'b1; m_mode[c] = M_REL;
            end else if (m_left[c] == 0) begin
              e_done[c] = 1'b1; m_mode[c] = M_REL;
            end
          end
          default: begin
            m_mode[c] = (m_pend[c] > 0) ? M_REQ : M_IDLE;
            m_wait[c] = 0;
          end
        endcase
        if (job_in[c]) begin
          if (took || m_pend[c] < QMAX) m_pend[c]++;
          else e_ovf = 1'b1;
        end
        if (took) m_pend[c]--;
        e_req[c]  = (m_mode[c] == M_REQ) || (m_mode[c] == M_XFER);
        e_xfer[c] = (m_mode[c] == M_XFER);
      end
    end
  endtask

  always @(posedge clock) model_step();

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_req", 32'(req), 32'(e_req));
      check("cyc_xfer", 32'(xfer), 32'(e_xfer));
      check("cyc_done", 32'(done), 32'(e_done));
      check("cyc_err_timeout", 32'(err_timeout), 32'(e_to));
      check("cyc_err_drop", 32'(err_drop), 32'(e_drop));
      check("cyc_err_spurious", 32'(err_spurious), 32'(e_spur));
      check("cyc_err_multi", 32'(err_multi), 32'(e_multi));
      check("cyc_err_ovf", 32'(err_ovf), 32'(e_ovf));
    end
  end

  // Apply the grant from the current outputs, then advance one clock (returns at a negedge)
  task automatic step();
    grant = manual_g | (req & auto_en);
    @(negedge clock);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1; step(); clr_err = 1'b0;
  endtask

  task automatic wait_xfer(input int ch, input string name);
    int n = 0;
    while (!xfer[ch] && n < 12) begin step(); n++; end
    if (!xfer[ch]) begin
      n_checks++; n_errors++;
      $display("FAIL %s: xfer never rose, got 0, expected 1", name);
    end
  endtask

  initial begin
    int nx, nd, nh;
    logic prev_done;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("rst_outputs", 32'({req, xfer, done, err_timeout, err_drop, err_spurious, err_multi, err_ovf}), 32'd0);
    reset_n = 1'b1;
    step(); step();

    // Basic burst on channel 0
    auto_en = 4'b0001;
    job_in = 4'b0001; step(); job_in = '0;
    check("t1_req_after_1", 32'(req[0]), 32'd0);
    step();
    check("t1_req_after_2", 32'(req[0]), 32'd1);
    nx = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      nx += int'(xfer[0]);
      nd += int'(done[0]);
      if (done[0]) check("t1_req_low_at_done", 32'(req[0]), 32'd0);
    end
    check("t1_xfer_cycles", 32'(nx), 32'd4);
    check("t1_done_pulses", 32'(nd), 32'd1);
    check("t1_errors_clean", 32'({err_timeout, err_drop, err_spurious, err_multi, err_ovf}), 32'd0);
    auto_en = '0;

    // Queueing and saturation on channel 2
    job_in = 4'b0100; repeat (9) step(); job_in = '0;
    check("t2_model_pend_sat", 32'(m_pend[2]), 32'd7);
    check("t2_err_ovf", 32'(err_ovf), 32'd1);
    auto_en = 4'b0100; nd = 0;
    for (int k = 0; k < 70; k++) begin
      step();
      if (done[2]) begin
        nd++;
        check("t2_req_low_at_done", 32'(req[2]), 32'd0);
      end
    end
    check("t2_done_pulses", 32'(nd), 32'd7);
    check("t2_no_timeout", 32'(err_timeout[2]), 32'd0);
    auto_en = '0;

    // Timeout on channel 1
    clear_errors();
    check("t3_ovf_cleared", 32'(err_ovf), 32'd0);
    job_in = 4'b0010; step(); job_in = '0;
    step();
    nh = 0;
    while (req[1] && nh < 40) begin nh++; step(); end
    check("t3_req_high_cycles", 32'(nh), 32'd15);
    check("t3_err_timeout_set", 32'(err_timeout[1]), 32'd1);
    step();
    check("t3_rerequest", 32'(req[1]), 32'd1);
    clear_errors();
    check("t3_timeout_cleared", 32'(err_timeout[1]), 32'd0);
    repeat (20) step();
    check("t3_timeout_again", 32'(err_timeout[1]), 32'd1);
    auto_en = 4'b0010; repeat (15) step(); auto_en = '0;

    // Protocol violations
    clear_errors();
    check("t4_flags_clear", 32'({err_timeout, err_drop, err_spurious, err_multi, err_ovf}), 32'd0);
    manual_g = 4'b1000; step(); manual_g = '0;
    check("t4_spurious", 32'(err_spurious), 32'd1);
    check("t4_multi_not_yet", 32'(err_multi), 32'd0);
    manual_g = 4'b0011; step(); manual_g = '0;
    check("t4_multi", 32'(err_multi), 32'd1);
    clear_errors();
    auto_en = 4'b0001; job_in = 4'b0001; step(); job_in = '0;
    wait_xfer(0, "t4_wait_xfer");
    step();
    auto_en = '0;
    nd = 0;
    for (int k = 0; k < 8; k++) begin step(); nd += int'(done[0]); end
    check("t4_drop_no_done", 32'(nd), 32'd0);
    check("t4_err_drop", 32'(err_drop[0]), 32'd1);

    // Reset in the middle of a burst
    clear_errors();
    auto_en = 4'b0001; job_in = 4'b0001; step(); job_in = '0;
    wait_xfer(0, "t5_wait_xfer");
    reset_n = 1'b0; step(); reset_n = 1'b1; auto_en = '0;
    check("t5_rst_outputs", 32'({req, xfer, done, err_timeout, err_drop, err_spurious, err_multi, err_ovf}), 32'd0);
    nd = 0;
    for (int k = 0; k < 6; k++) begin step(); nd += int'(done[0]); end
    check("t5_no_done_after_rst", 32'(nd), 32'd0);

    // Job arriving on the same edge the grant is accepted (channel 3)
    job_in = 4'b1000; step(); job_in = '0; step();
    check("t5_req3_up", 32'(req[3]), 32'd1);
    auto_en = 4'b1000; job_in = 4'b1000; step(); job_in = '0;
    check("t5_model_pend_hold", 32'(m_pend[3]), 32'd1);
    nd = 0; prev_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (prev_done && nd == 1) check("t5_rerequest_after_rel", 32'(req[3]), 32'd1);
      prev_done = done[3];
      nd += int'(done[3]);
    end
    check("t5_two_bursts", 32'(nd), 32'd2);
    auto_en = '0;
    step(); step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/arb_requester.md
# arb_requester

Client-side counterpart to the four-channel request/grant arbiter. It collects job pulses per channel and raises a request line for each channel with pending work. When granted, it holds the request for a fixed burst and then releases it. It also checks that the arbiter's grant behaviour is legal. It sits between local job sources and the arbiter's request inputs and grant outputs, and has one instance per client cluster.

## Interface
- NCH, 4: number of channels; `req` and `grant` bits share the same index.
- BURST, 4: data-phase length in cycles (1..15).
- TIMEOUT, 15: cycles a request may wait without a grant (1..255).
- QMAX, 7: saturation value of the per-channel pending-job counter (3-bit).

Ports:
- clock  in  1  single clock; all logic acts on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- job_in  in  NCH  one-cycle pulse per bit; each pulse adds one pending job to its channel.
- grant  in  NCH  grant from the arbiter; legal only while the channel's request is high.
- clr_err  in  1  one-cycle pulse that clears every sticky error flag.
- req  out  NCH  registered request to the arbiter.
- xfer  out  NCH  high during the channel's data phase.
- done  out  NCH  one-cycle pulse marking a completed burst.
- err_timeout  out  NCH  sticky: the channel waited TIMEOUT cycles without a grant.
- err_drop  out  NCH  sticky: grant was removed during the data phase.
- err_spurious  out  1  sticky: a grant arrived on a channel that was not requesting.
- err_multi  out  1  sticky: more than one grant bit was high in the same cycle.
- err_ovf  out  1  sticky: a job pulse arrived while that channel's counter was at QMAX.

## Operation
Each channel runs its own FSM with states IDLE, REQ, XFER and REL.
- IDLE
  - `req`=0.
  - If pending>0, go to REQ next cycle.
- REQ
  - `req`=1 and the wait counter increments.
  - If `grant[i]`=1, go to XFER, decrement pending, and load the burst counter with BURST.
  - Otherwise, if the wait counter reaches TIMEOUT, set `err_timeout[i]` and go to REL. The job stays pending.
- XFER
  - `req`=1 and `xfer`=1.
  - The burst counter decrements each cycle. At count 1, go to REL and pulse `done` in REL.
  - If `grant[i]`=0 in any XFER cycle, set `err_drop[i]` and go to REL with no `done` pulse. The job is lost.
- REL
  - `req`=0 for exactly one cycle, so the arbiter always sees a falling edge.
  - Next state is REQ if pending>0, otherwise IDLE.

Pending counter:
- A `job_in` pulse and a decrement in the same cycle leave the count unchanged.
- A `job_in` pulse at QMAX with no decrement drops the job and sets `err_ovf`.

Checkers (evaluated every cycle, all channels):
- `err_spurious`: `grant[i]`=1 while channel i is in IDLE or REL.
- `err_multi`: popcount(`grant`)>1.
- Each channel still acts only on its own grant bit. Checker flags never change FSM behaviour.
- If `clr_err` and a new error fall in the same cycle, the error wins and the flag ends up set.

Reset (`reset_n`=0 at a clock edge):
- All FSMs go to IDLE and all counters clear.
- `req`, `xfer`, `done` and every error flag are 0.
- Reset in the middle of a burst abandons it without a `done` pulse.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `job_in` at edge t in IDLE gives `req`=1 at edge t+2.
- `grant` sampled high at edge t gives `xfer`=1 from t+1 through t+BURST.
- `done` and `req`=0 are seen at t+BURST+1.
- With back-to-back work, the earliest re-request is t+BURST+2.
- Timeout: `req` high for TIMEOUT cycles, `err_timeout` set on the next edge, REL for one cycle, then REQ again.
- Channels are fully independent. Several channels may be in REQ at once.

## Test plan
- Basic burst:
  - Stimulus: reset, `job_in[0]` pulse at cycle 5, `grant[0]` held high from the first `req[0]` until `req[0]` falls.
  - Required: `req[0]` rises at 7, `xfer[0]` is high for 4 cycles, `done[0]` is a single pulse, then IDLE and all error flags stay 0.
- Queueing and saturation:
  - Stimulus: 9 pulses on `job_in[2]` with no grant, then grants to each request.
  - Required: `err_ovf`=1 and exactly 7 `done[2]` pulses, each separated by a one-cycle `req` low.
- Timeout:
  - Stimulus: `job_in[1]` and no grant for 40 cycles.
  - Required: `err_timeout[1]` is set after 15 request cycles, then `req[1]` goes low for one cycle and re-rises. After `clr_err`, the flag reads 0 until the next timeout.
- Protocol violations:
  - Stimulus: `grant[3]` while idle, `grant`=4'b0011, and `grant[0]` dropped in XFER cycle 2.
  - Required: `err_spurious`, `err_multi` and `err_drop[0]` are set, and no `done[0]` pulse for the dropped burst.
- Reset mid-burst and simultaneous events:
  - Stimulus: `reset_n` low during XFER; separately, `job_in` in the same cycle as grant acceptance with pending=1.
  - Required: after reset, all outputs are 0. In the second case, pending stays 1 and a new request follows REL.
